// File: rtl/fsize_hist_ctrl.sv
// Frame-size history controller: measures line length/count per video frame
// on a snooped AXI4-Stream bus and queues one 32-bit record per frame.
module fsize_hist_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 15
) (
    input  logic                      aclk,
    input  logic                      resetn,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tready,
    input  logic                      s_axis_tuser,
    input  logic                      s_axis_tlast,
    input  logic                      err_in,
    input  logic                      clr,
    input  logic                      fsize_hist_rd_en,
    output logic [31:0]               fsize_hist,
    output logic                      fsize_hist_full,
    output logic                      fsize_hist_empty,
    output logic [$clog2(DEPTH):0]    fsize_hist_level,
    output logic [15:0]               drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic        ovf;
        logic [14:0] line_cnt;
        logic        err;
        logic [14:0] line_len;
    } rec_t;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             commit_c;
    logic             cnt_en_c;

    logic             beat_c;
    logic             sof_c;
    logic             eol_c;

    logic [CNT_W-1:0] pix_cnt_q;
    logic [CNT_W-1:0] line_len_q;
    logic [CNT_W-1:0] line_cnt_q;
    logic             frame_err_q;
    logic             ovf_pending_q;

    rec_t             rec_c;
    rec_t             mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic             push_c;
    logic             pop_c;
    logic             drop_c;
    logic [LW-1:0]    level_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign beat_c = s_axis_tvalid & s_axis_tready;
    assign sof_c  = beat_c & s_axis_tuser;
    assign eol_c  = beat_c & s_axis_tlast;

    // Frame tracking state register
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q <= WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, commit strobe and counter enable
    always_comb begin
        state_d  = state_q;
        commit_c = 1'b0;
        cnt_en_c = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                if (sof_c) begin
                    state_d  = IN_FRAME;
                    cnt_en_c = 1'b1;
                end
            end
            IN_FRAME: begin
                cnt_en_c = beat_c;
                commit_c = sof_c & ~clr;
            end
            default: state_d = WAIT_SOF;
        endcase
        if (clr) begin
            state_d  = WAIT_SOF;
            cnt_en_c = 1'b0;
        end
    end

    // Pixel / line counters; an SOF beat always restarts them as pixel 1
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            pix_cnt_q  <= '0;
            line_len_q <= '0;
            line_cnt_q <= '0;
        end else if (clr) begin
            pix_cnt_q  <= '0;
            line_len_q <= '0;
            line_cnt_q <= '0;
        end else if (cnt_en_c) begin
            if (sof_c) begin
                pix_cnt_q  <= eol_c ? '0 : CNT_W'(1);
                line_len_q <= eol_c ? CNT_W'(1) : '0;
                line_cnt_q <= eol_c ? CNT_W'(1) : '0;
            end else if (eol_c) begin
                pix_cnt_q  <= '0;
                line_len_q <= sat_inc(pix_cnt_q);
                line_cnt_q <= sat_inc(line_cnt_q);
            end else begin
                pix_cnt_q  <= sat_inc(pix_cnt_q);
            end
        end
    end

    // Error flag: the commit cycle's err_in belongs to the new frame
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            frame_err_q <= 1'b0;
        end else if (clr) begin
            frame_err_q <= 1'b0;
        end else if (commit_c) begin
            frame_err_q <= err_in;
        end else if (state_q == IN_FRAME && err_in) begin
            frame_err_q <= 1'b1;
        end
    end

    always_comb begin
        rec_c          = '0;
        rec_c.ovf      = ovf_pending_q;
        rec_c.line_cnt = 15'(line_cnt_q);
        rec_c.err      = frame_err_q;
        rec_c.line_len = 15'(line_len_q);
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign pop_c   = fsize_hist_rd_en & ~fsize_hist_empty & ~clr;
    assign push_c  = commit_c & (~fsize_hist_full | pop_c);
    assign drop_c  = commit_c & fsize_hist_full & ~pop_c;
    assign level_d = fsize_hist_level + LW'(push_c) - LW'(pop_c);

    always_ff @(posedge aclk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= rec_c;
        end
    end

    // FIFO pointers, level and status flags
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            fsize_hist_level <= '0;
            fsize_hist_empty <= 1'b1;
            fsize_hist_full  <= 1'b0;
        end else if (clr) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            fsize_hist_level <= '0;
            fsize_hist_empty <= 1'b1;
            fsize_hist_full  <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            fsize_hist_level <= level_d;
            fsize_hist_empty <= (level_d == '0);
            fsize_hist_full  <= (level_d == LW'(DEPTH));
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            fsize_hist <= '0;
        end else if (clr) begin
            fsize_hist <= '0;
        end else if (pop_c) begin
            fsize_hist <= mem[rd_ptr_q];
        end
    end

    // Drop accounting: the next accepted record carries the overflow tag
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt      <= '0;
            ovf_pending_q <= 1'b0;
        end else if (clr) begin
            drop_cnt      <= '0;
            ovf_pending_q <= 1'b0;
        end else if (drop_c) begin
            if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            ovf_pending_q <= 1'b1;
        end else if (push_c) begin
            ovf_pending_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fsize_hist_ctrl.sv
// Self-checking bench for fsize_hist_ctrl: frame table plus corner-case sequences,
// with expected records queued at commit and checked when popped.
module tb_fsize_hist_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 15;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          aclk = 1'b0;
    logic          resetn;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tuser;
    logic          s_axis_tlast;
    logic          err_in;
    logic          clr;
    logic          fsize_hist_rd_en;
    logic [31:0]   fsize_hist;
    logic          fsize_hist_full;
    logic          fsize_hist_empty;
    logic [LW-1:0] fsize_hist_level;
    logic [15:0]   drop_cnt;

    fsize_hist_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .aclk             (aclk),
        .resetn           (resetn),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tuser     (s_axis_tuser),
        .s_axis_tlast     (s_axis_tlast),
        .err_in           (err_in),
        .clr              (clr),
        .fsize_hist_rd_en (fsize_hist_rd_en),
        .fsize_hist       (fsize_hist),
        .fsize_hist_full  (fsize_hist_full),
        .fsize_hist_empty (fsize_hist_empty),
        .fsize_hist_level (fsize_hist_level),
        .drop_cnt         (drop_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int          lines;
        int          len;
        int          err_beat;
        bit          gaps;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [6];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];
    int          m_level;
    int          m_drop;
    bit          m_ovf;
    bit          pend_valid;
    logic [31:0] pend_rec;
    logic [31:0] last_hist;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        s_axis_tvalid    = 1'b0;
        s_axis_tready    = 1'b0;
        s_axis_tuser     = 1'b0;
        s_axis_tlast     = 1'b0;
        err_in           = 1'b0;
        clr              = 1'b0;
        fsize_hist_rd_en = 1'b0;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_level    = 0;
        m_drop     = 0;
        m_ovf      = 1'b0;
        pend_valid = 1'b0;
        pend_rec   = '0;
        last_hist  = '0;
    endtask

    task automatic model_push(input bit pop_ok);
        if (m_level < DEPTH || pop_ok) begin
            exp_q.push_back(pend_rec | {m_ovf, 31'd0});
            m_ovf = 1'b0;
            if (!pop_ok) m_level++;
        end else begin
            m_drop++;
            m_ovf = 1'b1;
        end
    endtask

    task automatic check_status(input string name);
        check({name, "_level"}, 32'(fsize_hist_level), 32'(m_level));
        check({name, "_empty"}, 32'(fsize_hist_empty), 32'(m_level == 0));
        check({name, "_full"},  32'(fsize_hist_full),  32'(m_level == DEPTH));
        check({name, "_drop"},  32'(drop_cnt),         32'(m_drop));
    endtask

    task automatic do_beat(input bit sof, input bit eol, input bit err, input bit pop);
        s_axis_tvalid    = 1'b1;
        s_axis_tready    = 1'b1;
        s_axis_tuser     = sof;
        s_axis_tlast     = eol;
        err_in           = err;
        fsize_hist_rd_en = pop;
        tick();
        idle_inputs();
    endtask

    // Non-beat cycle with junk sideband bits that must be ignored
    task automatic gap_cycle(input int k);
        s_axis_tvalid = k[0];
        s_axis_tready = ~k[0];
        s_axis_tuser  = 1'b1;
        s_axis_tlast  = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic send_frame(input int lines, input int len, input int err_beat,
                              input bit gaps, input bit pop_sof, input logic [31:0] rec);
        int          b;
        bit          pop_ok;
        logic [31:0] popped;
        b      = 0;
        popped = '0;
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < len; p++) begin
                if (b == 0) begin
                    pop_ok = pop_sof && (m_level > 0);
                    if (pop_ok) popped = exp_q.pop_front();
                    if (pend_valid) model_push(pop_ok);
                    else if (pop_ok) m_level--;
                    do_beat(1'b1, p == len - 1, 1'b0, pop_sof);
                    if (pop_ok) begin
                        last_hist = popped;
                        check("pop_on_sof", fsize_hist, popped);
                    end
                end else begin
                    if (gaps) gap_cycle(b);
                    do_beat(1'b0, p == len - 1, b == err_beat, 1'b0);
                end
                b++;
            end
        end
        pend_valid = 1'b1;
        pend_rec   = rec;
    endtask

    task automatic pop_check(input string name);
        logic [31:0] e;
        if (m_level == 0) begin
            e = last_hist;
        end else begin
            e = exp_q.pop_front();
            m_level--;
        end
        fsize_hist_rd_en = 1'b1;
        tick();
        fsize_hist_rd_en = 1'b0;
        last_hist = e;
        check(name, fsize_hist, e);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
    endtask

    // Builds a history of five 2x3 records with one already popped
    task automatic build_mid_frame();
        pulse_clr();
        for (int i = 0; i < 7; i++) send_frame(2, 3, -1, 1'b0, 1'b0, 32'h0002_0003);
        pop_check("mid_pop");
        do_beat(1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_level", 32'(fsize_hist_level), 32'd5);
    endtask

    initial begin
        tbl[0] = '{lines: 3, len: 4, err_beat: -1, gaps: 1'b0, exp: 32'h0003_0004};
        tbl[1] = '{lines: 3, len: 4, err_beat: 5,  gaps: 1'b0, exp: 32'h0003_8004};
        tbl[2] = '{lines: 2, len: 5, err_beat: -1, gaps: 1'b1, exp: 32'h0002_0005};
        tbl[3] = '{lines: 1, len: 1, err_beat: -1, gaps: 1'b0, exp: 32'h0001_0001};
        tbl[4] = '{lines: 4, len: 2, err_beat: -1, gaps: 1'b1, exp: 32'h0004_0002};
        tbl[5] = '{lines: 5, len: 3, err_beat: 4,  gaps: 1'b1, exp: 32'h0005_8003};

        idle_inputs();
        model_clear();
        resetn = 1'b0;
        repeat (3) tick();
        check_status("reset");
        check("reset_hist", fsize_hist, 32'h0);
        resetn = 1'b1;
        tick();

        // Table of frames, each committed by the next SOF
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].lines, tbl[i].len, tbl[i].err_beat, tbl[i].gaps, 1'b0, tbl[i].exp);
        end
        send_frame(1, 1, -1, 1'b0, 1'b0, 32'h0001_0001);
        check_status("table");
        while (m_level > 0) pop_check("table_pop");
        check_status("drained");
        pop_check("pop_empty_hold");

        // Beats before the first SOF produce nothing
        pulse_clr();
        check_status("clr");
        check("clr_hist", fsize_hist, 32'h0);
        do_beat(1'b0, 1'b1, 1'b0, 1'b0);
        do_beat(1'b0, 1'b0, 1'b1, 1'b0);
        do_beat(1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(1, 2, -1, 1'b0, 1'b0, 32'h0001_0002);
        check_status("pre_sof");
        send_frame(1, 1, -1, 1'b0, 1'b0, 32'h0001_0001);
        check_status("first_commit");
        pop_check("first_pop");

        // Overflow: 18 commits into 16 slots
        pulse_clr();
        for (int i = 0; i < 19; i++) send_frame(1, 3, -1, 1'b0, 1'b0, 32'h0001_0003);
        check_status("ovf");
        check("ovf_drop_const", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 16; i++) pop_check("ovf_pop");
        send_frame(1, 3, -1, 1'b0, 1'b0, 32'h0001_0003);
        pop_check("ovf_tag_pop");
        check("ovf_tag_const", fsize_hist, 32'h8001_0003);
        check_status("ovf_after");

        // Full FIFO with a pop in the commit cycle
        pulse_clr();
        for (int i = 0; i < 17; i++) send_frame(1, 3, -1, 1'b0, 1'b0, 32'h0001_0003);
        check_status("full");
        send_frame(1, 3, -1, 1'b0, 1'b1, 32'h0001_0003);
        check_status("full_pushpop");
        for (int i = 0; i < 16; i++) pop_check("full_drain");
        check("full_last_no_tag", fsize_hist, 32'h0001_0003);

        // clr mid-frame with a concurrent SOF beat and pop request
        build_mid_frame();
        s_axis_tvalid    = 1'b1;
        s_axis_tready    = 1'b1;
        s_axis_tuser     = 1'b1;
        fsize_hist_rd_en = 1'b1;
        clr              = 1'b1;
        tick();
        idle_inputs();
        model_clear();
        check_status("clr_mid");
        check("clr_mid_hist", fsize_hist, 32'h0);
        send_frame(1, 2, -1, 1'b0, 1'b0, 32'h0001_0002);
        check_status("clr_mid_sof");

        // Asynchronous reset mid-frame, checked before the next clock edge
        build_mid_frame();
        #2 resetn = 1'b0;
        #1;
        model_clear();
        check_status("rst_mid");
        check("rst_mid_hist", fsize_hist, 32'h0);
        tick();
        resetn = 1'b1;
        tick();
        send_frame(1, 2, -1, 1'b0, 1'b0, 32'h0001_0002);
        check_status("rst_mid_sof");
        send_frame(1, 1, -1, 1'b0, 1'b0, 32'h0001_0001);
        pop_check("rst_mid_pop");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fsize_hist_ctrl.md
# fsize_hist_ctrl

Frame-size history controller for the video debug module. It snoops the monitored AXI4-Stream video bus, measures line length and line count of every frame, and buffers one packed 32-bit record per frame in an internal FIFO. The register block drains the FIFO through the frame-size-history read port: `fsize_hist_rd_en` pops one record, and `fsize_hist` holds that record.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of 2, range 2..256.
- CNT_W, 15: width of the line-length and line-count counters; must be ≤ 15.

Ports:
- aclk  in  1  single clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  1  monitored bus valid (snoop only).
- s_axis_tready  in  1  monitored bus ready (snoop only).
- s_axis_tuser  in  1  start of frame (SOF), qualified by a beat.
- s_axis_tlast  in  1  end of line (EOL), qualified by a beat.
- err_in  in  1  level; any frame-size error detected this cycle.
- clr  in  1  synchronous clear of FIFO, counters and flags.
- fsize_hist_rd_en  in  1  pop request from the register block.
- fsize_hist  out  32  last popped record.
- fsize_hist_full  out  1  FIFO holds DEPTH entries.
- fsize_hist_empty  out  1  FIFO holds 0 entries.
- fsize_hist_level  out  $clog2(DEPTH)+1  current entry count.
- drop_cnt  out  16  records dropped on full; saturates at 16'hFFFF.

## Operation
- Beat: s_axis_tvalid & s_axis_tready. Non-beat cycles change no counters.
- FSM states:
  - WAIT_SOF (reset state): ignores beats until a beat with tuser=1, then moves to IN_FRAME.
  - IN_FRAME: stays here; every later SOF beat commits the finished frame.
- Counters, active in IN_FRAME and on the entering SOF beat:
  - pix_cnt increments on every beat.
  - On a tlast beat: line_len <= pix_cnt+1, pix_cnt <= 0, line_cnt <= line_cnt+1.
  - All counters saturate at 2^CNT_W-1.
- SOF beat while in IN_FRAME (commit):
  - Record pushed: bits [CNT_W-1:0] = line_len, bit 15 = frame_err, bits [16+CNT_W-1:16] = line_cnt, bit 31 = ovf_pending. Unused bits are 0.
  - Counters then restart with this beat as pixel 1. If tlast is also set: line_len=1, line_cnt=1, pix_cnt=0.
- frame_err is set by err_in in any IN_FRAME cycle. On commit it reloads with that cycle's err_in.
- Push when full with no same-cycle pop:
  - The record is dropped, drop_cnt increments (saturating), ovf_pending <= 1.
  - The next accepted push carries bit 31=1 and clears ovf_pending.
- Pop (rd_en & ~empty): fsize_hist <= head record, read pointer advances.
- Pop when empty: ignored; fsize_hist is held.
- Simultaneous push and pop:
  - Both take effect and level is unchanged.
  - When full, the pop frees the slot, so the push is accepted (no drop).
  - When empty, only the push happens.
- Pointers wrap modulo DEPTH. Level is tracked explicitly, so full and empty are unambiguous.
- clr:
  - Empties the FIFO and zeroes level, drop_cnt, ovf_pending, frame_err and all counters.
  - Returns the FSM to WAIT_SOF. fsize_hist is zeroed.
  - clr has priority over same-cycle push and pop.

## Timing
- Reset values: fsize_hist=0, fsize_hist_full=0, fsize_hist_empty=1, fsize_hist_level=0, drop_cnt=0; FSM=WAIT_SOF.
- Reset is asynchronous. Assertion mid-frame or mid-pop discards all state immediately.
- All outputs are registered.
- Push latency: a commit on SOF beat cycle N updates level, empty and full at the edge ending cycle N.
- Pop latency: rd_en in cycle N gives the new fsize_hist from cycle N+1, held until the next valid pop. This matches the register block's one-cycle gap between the AR handshake and the read-data phase.
- Sustained throughput: one push and one pop per cycle.

## Test plan
- Nominal frame: after reset, send SOF, then 3 lines of 4 beats with tlast on each 4th, then SOF. Level goes 0→1. Pulse rd_en; next cycle fsize_hist=32'h0003_0004 and empty=1.
- Error tag: same frame with one err_in pulse mid-frame. Popped record = 32'h0003_8004, and the following frame's bit 15 = 0.
- Overflow (DEPTH=16): commit 18 frames with no pops. Then full=1, level=16, drop_cnt=2. Pop 16 records, commit one more; that record has bit 31=1.
- Full with simultaneous push and pop: with the FIFO full, assert rd_en in the commit cycle. Level stays 16, drop_cnt is unchanged, and bit 31 of the next pushed record = 0.
- Edge cases: pop while empty leaves fsize_hist unchanged. Beats before the first SOF produce no record. Gaps in tvalid/tready (non-beat cycles) do not change counts.
- Reset mid-operation: assert clr, then separately resetn, in the middle of a frame with level=5. Both give level=0, empty=1, drop_cnt=0, fsize_hist=0, and the next SOF only opens a frame with no record.
